// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the ALU interface in the 16-bit RISC core. Accepts one
// instruction at a time over instr_valid/instr_ready, reads its operands from
// an internal NREG x DW register file, drives a/b/op to the external
// combinational alu for one full cycle, captures ans/zero/carry, reports the
// result for one cycle and writes it back to rd. Throughput is one
// instruction every three cycles (IDLE -> EXEC -> WB).
//
// Instruction format: [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] imm5
//   op: 00 ADD, 01 SUB, 10 SHIFT (b = imm5: bit0 0=LSL 1=LSR, [4:1] amount),
//       11 NAND
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr                 16-bit instruction
//   ext_we/addr/wdata     register preload port, honoured in any state
//   alu_a/alu_b/alu_op    registered operands and opcode to the alu
//   alu_ans/zero/carry    alu result, zero flag, carry (ADD carry / SUB borrow)
//   res_valid, res_data   one-cycle result strobe and captured result
//   flag_z, flag_c        sticky flags, updated on every writeback
//   flag_v                sticky signed-overflow flag (ALU_CTRL_OVF_EN only)
//   busy                  high in EXEC and WB
//
// Configuration
//   ALU_CTRL_OVF_EN       when defined, adds the flag_v output and the
//                         overflow logic; undefined by default.
//
// r0 always reads zero; writes to r0 from either port are dropped.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [15:0]             instr,
    input  logic                    ext_we,
    input  logic [$clog2(NREG)-1:0] ext_addr,
    input  logic [DW-1:0]           ext_wdata,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [1:0]              alu_op,
    input  logic [DW-1:0]           alu_ans,
    input  logic                    alu_zero,
    input  logic                    alu_carry,
    output logic                    res_valid,
    output logic [DW-1:0]           res_data,
    output logic                    flag_z,
    output logic                    flag_c,
`ifdef ALU_CTRL_OVF_EN
    output logic                    flag_v,
`endif
    output logic                    busy
);

    localparam int AW = $clog2(NREG);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic [1:0]      alu_op_q;
    logic [DW-1:0]   res_q;
    logic            res_valid_q;
    logic            flag_z_q;
    logic            flag_c_q;
    logic [DW-1:0]   rf_q [NREG];

    // -----------------------------------------------------------------------
    // Instruction decode and operand fetch (combinational, used on accept)
    // -----------------------------------------------------------------------
    logic [1:0]      dec_op;
    logic [AW-1:0]   dec_rd;
    logic [AW-1:0]   dec_rs1;
    logic [AW-1:0]   dec_rs2;
    logic [4:0]      dec_imm;
    logic [DW-1:0]   alu_a_d;
    logic [DW-1:0]   alu_b_d;
    logic            wb_we;

    assign dec_op  = instr[15:14];
    assign dec_rd  = instr[13:11];
    assign dec_rs1 = instr[10:8];
    assign dec_rs2 = instr[7:5];
    assign dec_imm = instr[4:0];

    // r0 is never written and clears on reset, so a plain read returns zero.
    assign alu_a_d = rf_q[dec_rs1];
    assign alu_b_d = (dec_op == OP_SHIFT) ? {{(DW-5){1'b0}}, dec_imm}
                                          : rf_q[dec_rs2];

    assign wb_we = (state_q == S_WB) && (rd_q != '0);

`ifdef ALU_CTRL_OVF_EN
    logic flag_v_q;
    logic ovf_d;

    // NOTE: every signal assigned in always_comb gets a default first so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        ovf_d = 1'b0;
        case (alu_op_q)
            OP_ADD: ovf_d = (alu_a_q[DW-1] == alu_b_q[DW-1]) &&
                            (alu_ans[DW-1] != alu_a_q[DW-1]);
            OP_SUB: ovf_d = (alu_a_q[DW-1] != alu_b_q[DW-1]) &&
                            (alu_ans[DW-1] != alu_a_q[DW-1]);
            default: ovf_d = 1'b0;
        endcase
    end
`endif

    // -----------------------------------------------------------------------
    // Control FSM with registered datapath outputs
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
`ifdef ALU_CTRL_OVF_EN
            flag_v_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    res_valid_q <= 1'b0;
                    if (instr_valid) begin
                        rd_q     <= dec_rd;
                        alu_a_q  <= alu_a_d;
                        alu_b_q  <= alu_b_d;
                        alu_op_q <= dec_op;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // alu inputs have been stable for the whole cycle.
                    res_q       <= alu_ans;
                    flag_z_q    <= alu_zero;
                    flag_c_q    <= alu_carry;
`ifdef ALU_CTRL_OVF_EN
                    flag_v_q    <= ovf_d;
`endif
                    res_valid_q <= 1'b1;
                    state_q     <= S_WB;
                end
                S_WB: begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register file: writeback port has priority over the preload port when
    // both target the same register on the same edge.
    // -----------------------------------------------------------------------
    // NOTE: this storage is architecturally cleared by reset, so it is built
    // from resettable flops rather than a RAM that cannot be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_we && (rd_q == AW'(i))) begin
                    rf_q[i] <= res_q;
                end else if (ext_we && (ext_addr == AW'(i))) begin
                    rf_q[i] <= ext_wdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
`ifdef ALU_CTRL_OVF_EN
    assign flag_v      = flag_v_q;
`endif

endmodule
